// File: rtl/bsg_fsb_loopback_checker_pkg.sv
//------------------------------------------------------------------------------
// bsg_fsb_loopback_checker_pkg : shared state encoding and lane pattern function
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package bsg_fsb_loopback_checker_pkg;

   typedef enum logic [1:0] {
      e_idle  = 2'd0,
      e_sync  = 2'd1,
      e_check = 2'd2,
      e_fail  = 2'd3
   } chk_state_e;

   // Full-precision lane value; callers truncate to the lane width, which is the mod.
   function automatic logic [31:0] pattern_lane(input logic [31:0] k,
                                                input logic [31:0] c,
                                                input logic [31:0] num_channels);
      return k * num_channels + c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_fsb_loopback_lane_gen.sv
//------------------------------------------------------------------------------
// bsg_fsb_loopback_lane_gen : expected pattern word for word index k_i
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bsg_fsb_loopback_lane_gen
   import bsg_fsb_loopback_checker_pkg::*;
#(
   parameter int channel_width_p = 8,
   parameter int num_channels_p  = 8
) (
   input  logic [channel_width_p-1:0]                k_i,
   output logic [channel_width_p*num_channels_p-1:0] data_o
);

   for (genvar c = 0; c < num_channels_p; c++) begin : g_lane
      assign data_o[c*channel_width_p +: channel_width_p] =
         channel_width_p'(pattern_lane(32'(k_i), 32'(c), 32'(num_channels_p)));
   end

endmodule

`default_nettype wire

// File: rtl/bsg_fsb_loopback_checker.sv
//------------------------------------------------------------------------------
// bsg_fsb_loopback_checker : per-node snooping checker for FSB loopback patterns
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bsg_fsb_loopback_checker
   import bsg_fsb_loopback_checker_pkg::*;
#(
   parameter int ring_width_p    = 80,
   parameter int nodes_p         = 1,
   parameter int channel_width_p = 8,
   parameter int num_channels_p  = 8,
   parameter int cnt_width_p     = 16,
   parameter int sync_words_p    = 2
) (
   input  logic                                              clk_i,
   input  logic                                              reset_n_i,
   input  logic [nodes_p-1:0]                                en_i,
   input  logic [nodes_p-1:0]                                node_reset_i,
   input  logic                                              stop_on_err_i,
   input  logic [nodes_p-1:0]                                v_i,
   input  logic [nodes_p-1:0]                                ready_i,
   input  logic [nodes_p*ring_width_p-1:0]                   data_i,
   output logic [nodes_p-1:0]                                locked_o,
   output logic [nodes_p-1:0]                                pass_o,
   output logic [nodes_p-1:0]                                fail_o,
   output logic [nodes_p*cnt_width_p-1:0]                    word_cnt_o,
   output logic [nodes_p*cnt_width_p-1:0]                    err_cnt_o,
   output logic [nodes_p*channel_width_p*num_channels_p-1:0] first_err_o,
   output logic [nodes_p*channel_width_p*num_channels_p-1:0] first_exp_o
);

   localparam int                     c_chk_w      = channel_width_p * num_channels_p;
   localparam int                     c_run_w      = $clog2(sync_words_p + 1);
   localparam logic [c_run_w-1:0]     c_sync_words = c_run_w'(sync_words_p);
   localparam logic [c_run_w-1:0]     c_run_one    = c_run_w'(1);
   localparam logic [cnt_width_p-1:0] c_cnt_one    = cnt_width_p'(1);
   localparam logic [channel_width_p-1:0] c_k_one  = channel_width_p'(1);

   for (genvar n = 0; n < nodes_p; n++) begin : g_node
      logic [c_chk_w-1:0]         w_rx;
      logic [c_chk_w-1:0]         w_exp;
      logic [channel_width_p-1:0] w_lane0;
      logic [channel_width_p-1:0] w_sync_k;
      logic [c_run_w-1:0]         w_run_inc;
      logic                       w_xfer;
      logic                       w_match;
      logic                       w_pattern_ok;
      logic                       w_locked_nxt;

      chk_state_e                 r_state,     w_state_nxt;
      logic [channel_width_p-1:0] r_k,         w_k_nxt;
      logic [c_run_w-1:0]         r_run,       w_run_nxt;
      logic [cnt_width_p-1:0]     r_word,      w_word_nxt;
      logic [cnt_width_p-1:0]     r_err,       w_err_nxt;
      logic [c_chk_w-1:0]         r_first_err, w_first_err_nxt;
      logic [c_chk_w-1:0]         r_first_exp, w_first_exp_nxt;
      logic                       r_locked;
      logic                       r_pass;
      logic                       r_fail;

      if (c_chk_w < ring_width_p) begin : g_spare
         logic w_spare_unused;
         assign w_spare_unused = ^data_i[n*ring_width_p + c_chk_w +: ring_width_p - c_chk_w];
      end

      assign w_rx      = data_i[n*ring_width_p +: c_chk_w];
      assign w_lane0   = w_rx[channel_width_p-1:0];
      assign w_xfer    = v_i[n] & ready_i[n];
      assign w_match   = (w_rx == w_exp);
      assign w_run_inc = r_run + c_run_one;
      // A synced word at index lane0/N means the next expected word is one past it.
      assign w_sync_k  = channel_width_p'(32'(w_lane0) / 32'(num_channels_p) + 32'd1);

      bsg_fsb_loopback_lane_gen #(
         .channel_width_p (channel_width_p),
         .num_channels_p  (num_channels_p)
      ) u_lane_gen (
         .k_i    (r_k),
         .data_o (w_exp)
      );

      always_comb begin
         w_pattern_ok = 1'b1;
         for (int c = 1; c < num_channels_p; c++) begin
            if (w_rx[c*channel_width_p +: channel_width_p] !=
                channel_width_p'(32'(w_lane0) + 32'(c)))
               w_pattern_ok = 1'b0;
         end
      end

      always_comb begin
         w_state_nxt     = r_state;
         w_k_nxt         = r_k;
         w_run_nxt       = r_run;
         w_word_nxt      = r_word;
         w_err_nxt       = r_err;
         w_first_err_nxt = r_first_err;
         w_first_exp_nxt = r_first_exp;
         case (r_state)
            e_idle: begin
               if (en_i[n]) begin
                  w_state_nxt = e_sync;
                  w_run_nxt   = '0;
               end
            end
            e_sync: begin
               if (w_xfer) begin
                  if (w_pattern_ok) begin
                     w_k_nxt   = w_sync_k;
                     w_run_nxt = w_run_inc;
                     if (w_run_inc >= c_sync_words)
                        w_state_nxt = e_check;
                  end else begin
                     w_run_nxt = '0;
                  end
               end
            end
            default: begin
               if (w_xfer) begin
                  w_k_nxt = r_k + c_k_one;
                  if (r_word != '1)
                     w_word_nxt = r_word + c_cnt_one;
                  if (!w_match) begin
                     if (r_err != '1)
                        w_err_nxt = r_err + c_cnt_one;
                     if (r_err == '0) begin
                        w_first_err_nxt = w_rx;
                        w_first_exp_nxt = w_exp;
                     end
                     if (r_state == e_check && stop_on_err_i)
                        w_state_nxt = e_fail;
                  end
               end
            end
         endcase
         // The transfer above still counts; losing enable only parks the node.
         if (!en_i[n])
            w_state_nxt = e_idle;
      end

      assign w_locked_nxt = (w_state_nxt == e_check) || (w_state_nxt == e_fail);

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            r_state     <= e_idle;
            r_k         <= '0;
            r_run       <= '0;
            r_word      <= '0;
            r_err       <= '0;
            r_first_err <= '0;
            r_first_exp <= '0;
            r_locked    <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
         end else if (node_reset_i[n]) begin
            r_state     <= e_idle;
            r_k         <= '0;
            r_run       <= '0;
            r_word      <= '0;
            r_err       <= '0;
            r_first_err <= '0;
            r_first_exp <= '0;
            r_locked    <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
         end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_run       <= w_run_nxt;
            r_word      <= w_word_nxt;
            r_err       <= w_err_nxt;
            r_first_err <= w_first_err_nxt;
            r_first_exp <= w_first_exp_nxt;
            r_locked    <= w_locked_nxt;
            r_pass      <= w_locked_nxt && (w_err_nxt == '0) && (w_word_nxt != '0);
            r_fail      <= (w_err_nxt != '0);
         end
      end

      assign locked_o[n]                                = r_locked;
      assign pass_o[n]                                  = r_pass;
      assign fail_o[n]                                  = r_fail;
      assign word_cnt_o[n*cnt_width_p +: cnt_width_p]   = r_word;
      assign err_cnt_o[n*cnt_width_p +: cnt_width_p]    = r_err;
      assign first_err_o[n*c_chk_w +: c_chk_w]          = r_first_err;
      assign first_exp_o[n*c_chk_w +: c_chk_w]          = r_first_exp;
   end

endmodule

`default_nettype wire

// File: tb/tb_bsg_fsb_loopback_checker.sv
//------------------------------------------------------------------------------
// tb_bsg_fsb_loopback_checker : directed bench, three snooped nodes, 6-bit counters
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bsg_fsb_loopback_checker;

   localparam int NODES = 3;
   localparam int RW    = 80;
   localparam int CW    = 6;
   localparam int CHK   = 64;

   logic                  clk_50_mhz = 1'b0;
   logic                  reset_n;
   logic [NODES-1:0]      en;
   logic [NODES-1:0]      node_reset;
   logic                  stop_on_err;
   logic [NODES-1:0]      v;
   logic [NODES-1:0]      ready;
   logic [NODES*RW-1:0]   data;
   logic [NODES-1:0]      locked;
   logic [NODES-1:0]      pass;
   logic [NODES-1:0]      fail;
   logic [NODES*CW-1:0]   word_cnt;
   logic [NODES*CW-1:0]   err_cnt;
   logic [NODES*CHK-1:0]  first_err;
   logic [NODES*CHK-1:0]  first_exp;

   int n_cmp = 0;
   int n_mis = 0;

   always #10 clk_50_mhz = ~clk_50_mhz;

   bsg_fsb_loopback_checker #(
      .ring_width_p    (RW),
      .nodes_p         (NODES),
      .channel_width_p (8),
      .num_channels_p  (8),
      .cnt_width_p     (CW),
      .sync_words_p    (2)
   ) dut (
      .clk_i         (clk_50_mhz),
      .reset_n_i     (reset_n),
      .en_i          (en),
      .node_reset_i  (node_reset),
      .stop_on_err_i (stop_on_err),
      .v_i           (v),
      .ready_i       (ready),
      .data_i        (data),
      .locked_o      (locked),
      .pass_o        (pass),
      .fail_o        (fail),
      .word_cnt_o    (word_cnt),
      .err_cnt_o     (err_cnt),
      .first_err_o   (first_err),
      .first_exp_o   (first_exp)
   );

   function automatic logic [63:0] pat_word(input int k);
      logic [63:0] w;
      int          t;
      for (int c = 0; c < 8; c++) begin
         t = k * 8 + c;
         w[c*8 +: 8] = t[7:0];
      end
      return w;
   endfunction

   function automatic logic [63:0] bad_word(input int k);
      logic [63:0] w;
      w = pat_word(k);
      w[31:24] = 8'hFF;
      return w;
   endfunction

   function automatic logic [63:0] wcnt(input int n);
      return 64'(word_cnt[n*CW +: CW]);
   endfunction

   function automatic logic [63:0] ecnt(input int n);
      return 64'(err_cnt[n*CW +: CW]);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50_mhz);
      #1;
   endtask

   task automatic put_word(input int n, input int k, input bit bad);
      data[n*RW +: RW] = {16'hABCD, (bad ? bad_word(k) : pat_word(k))};
   endtask

   task automatic send(input logic [2:0] mask, input int k_first, input int k_last,
                       input int bad_node, input int bad_a, input int bad_b, input bit bad_all);
      for (int k = k_first; k <= k_last; k++) begin
         for (int n = 0; n < NODES; n++)
            put_word(n, k, (n == bad_node) && (bad_all || k == bad_a || k == bad_b));
         v = mask;
         tick();
      end
      v = '0;
   endtask

   task automatic pulse_node_reset(input logic [2:0] mask);
      node_reset = mask;
      tick();
      node_reset = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n     = 1'b0;
      en          = '0;
      node_reset  = '0;
      stop_on_err = 1'b0;
      v           = '0;
      ready       = '1;
      data        = '0;
      tick();
      tick();
      check("reset_locked",   64'(locked),   64'd0);
      check("reset_pass",     64'(pass),     64'd0);
      check("reset_fail",     64'(fail),     64'd0);
      check("reset_word_cnt", 64'(word_cnt), 64'd0);
      check("reset_err_cnt",  64'(err_cnt),  64'd0);
      reset_n = 1'b1;

      // transfers while disabled are ignored
      send(3'b001, 0, 1, -1, -1, -1, 1'b0);
      check("idle_ignore_locked", 64'(locked[0]), 64'd0);
      check("idle_ignore_words",  wcnt(0),        64'd0);

      // clean stream from k=0; two sync words then checking
      en[0] = 1'b1;
      tick();
      send(3'b001, 0, 0, -1, -1, -1, 1'b0);
      check("sync_one_word_not_locked", 64'(locked[0]), 64'd0);
      send(3'b001, 1, 1, -1, -1, -1, 1'b0);
      check("sync_two_words_locked", 64'(locked[0]), 64'd1);
      check("sync_no_counting",      wcnt(0),        64'd0);
      send(3'b001, 2, 5, -1, -1, -1, 1'b0);
      put_word(0, 6, 1'b0);
      v = 3'b001;
      ready = 3'b000;
      tick();
      v = '0;
      ready = '1;
      check("valid_without_ready", wcnt(0), 64'd4);
      send(3'b001, 6, 9, -1, -1, -1, 1'b0);
      check("clean_word_cnt", wcnt(0),           64'd8);
      check("clean_err_cnt",  ecnt(0),           64'd0);
      check("clean_pass",     64'(pass[0]),      64'd1);
      check("clean_fail",     64'(fail[0]),      64'd0);

      // single corruption, keep checking
      pulse_node_reset(3'b001);
      check("node_reset_words",  wcnt(0),           64'd0);
      check("node_reset_locked", 64'(locked[0]),    64'd0);
      tick();
      send(3'b001, 0, 9, 0, 5, -1, 1'b0);
      check("err_word_cnt",       wcnt(0),                64'd8);
      check("err_err_cnt",        ecnt(0),                64'd1);
      check("err_locked",         64'(locked[0]),         64'd1);
      check("err_fail",           64'(fail[0]),           64'd1);
      check("err_pass",           64'(pass[0]),           64'd0);
      check("err_first_exp_lane3", 64'(first_exp[31:24]), 64'h2B);
      check("err_first_exp",      first_exp[63:0],        64'h2F2E2D2C2B2A2928);
      check("err_first_err",      first_err[63:0],        64'h2F2E2D2CFF2A2928);

      // stop on error, second corruption still counted, capture unchanged
      pulse_node_reset(3'b001);
      stop_on_err = 1'b1;
      tick();
      send(3'b001, 0, 9, 0, 5, 7, 1'b0);
      check("stop_err_cnt",    ecnt(0),          64'd2);
      check("stop_word_cnt",   wcnt(0),          64'd8);
      check("stop_fail",       64'(fail[0]),     64'd1);
      check("stop_locked",     64'(locked[0]),   64'd1);
      check("stop_first_err",  first_err[63:0],  64'h2F2E2D2CFF2A2928);
      // enable drops on the same cycle as a clean transfer
      en[0] = 1'b0;
      put_word(0, 10, 1'b0);
      v = 3'b001;
      tick();
      v = '0;
      check("en_fall_word_counted", wcnt(0),        64'd9);
      check("en_fall_err_held",     ecnt(0),        64'd2);
      check("en_fall_unlocked",     64'(locked[0]), 64'd0);

      // start mid-sequence at k=200 and wrap through k=255 -> 0
      stop_on_err = 1'b0;
      en[0] = 1'b1;
      pulse_node_reset(3'b001);
      tick();
      send(3'b001, 200, 201, -1, -1, -1, 1'b0);
      check("k200_locked", 64'(locked[0]), 64'd1);
      send(3'b001, 202, 259, -1, -1, -1, 1'b0);
      check("wrap_word_cnt", wcnt(0),      64'd58);
      check("wrap_err_cnt",  ecnt(0),      64'd0);
      check("wrap_pass",     64'(pass[0]), 64'd1);

      // three nodes, node1 corrupted then reset mid-stream
      pulse_node_reset(3'b111);
      en = 3'b111;
      tick();
      send(3'b111, 0, 7, 1, 4, 6, 1'b0);
      check("n1_err_before_reset",  ecnt(1), 64'd2);
      check("n1_word_before_reset", wcnt(1), 64'd6);
      check("n0_word_mid",          wcnt(0), 64'd6);
      node_reset = 3'b010;
      for (int n = 0; n < NODES; n++) put_word(n, 8, 1'b0);
      v = 3'b111;
      tick();
      v = '0;
      node_reset = '0;
      check("n1_reset_words",     wcnt(1),              64'd0);
      check("n1_reset_errs",      ecnt(1),              64'd0);
      check("n1_reset_locked",    64'(locked[1]),       64'd0);
      check("n1_reset_first_err", first_err[127:64],    64'd0);
      check("n0_unaffected",      wcnt(0),              64'd7);
      send(3'b111, 9, 15, -1, -1, -1, 1'b0);
      check("n1_resync_words", wcnt(1),      64'd4);
      check("n1_resync_pass",  64'(pass[1]), 64'd1);
      check("n0_final_words",  wcnt(0),      64'd14);
      check("n2_final_words",  wcnt(2),      64'd14);
      check("n0_n2_pass",      64'({pass[2], pass[0]}), 64'd3);

      // saturation: node2 sees a long run of corrupted words
      send(3'b100, 16, 85, 2, -1, -1, 1'b1);
      check("sat_err_cnt",    ecnt(2),             64'd63);
      check("sat_word_cnt",   wcnt(2),             64'd63);
      check("sat_first_exp",  first_exp[191:128],  64'h878685848382_8180);
      check("sat_first_err",  first_err[191:128],  64'h87868584FF828180);
      check("sat_n0_held",    wcnt(0),             64'd14);

      // asynchronous reset, sampled before any clock edge
      #2;
      reset_n = 1'b0;
      #1;
      check("async_locked",    64'(locked),   64'd0);
      check("async_fail",      64'(fail),     64'd0);
      check("async_pass",      64'(pass),     64'd0);
      check("async_word_cnt",  64'(word_cnt), 64'd0);
      check("async_err_cnt",   64'(err_cnt),  64'd0);
      check("async_first_err", 64'(|first_err), 64'd0);
      check("async_first_exp", 64'(|first_exp), 64'd0);
      reset_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
